writeback_xcpt_arbiter: RTL and testbench

- Parametrised successor of the per-unit writeback exception translation.
- Takes NUM_WB_CH writeback channels and converts each exception-bearing writeback into reorder_buffer_xcpt_info_t, using a fixed priority.
- Buffers one pending exception per channel, keeping the oldest by RoB age relative to the RoB head.
- Presents one exception at a time to the reorder buffer over a valid/ready handshake, and supports pipeline flush.

---
 rtl/writeback_xcpt_arbiter_pkg.sv | 53 +++++
 rtl/writeback_xcpt_arbiter_decode.sv | 17 +
 rtl/writeback_xcpt_arbiter.sv | 84 ++++++++
 tb/tb_writeback_xcpt_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_xcpt_arbiter_pkg.sv
// writeback_xcpt_arbiter_pkg: exception type enum, writeback request / RoB exception structs, rob_idx_t and record builder
package writeback_xcpt_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int DEF_ROB_IDX_W = 3;
  typedef logic [DEF_ROB_IDX_W-1:0] rob_idx_t;
  typedef enum logic [2:0] {
    xcpt_none,
    iTlb_miss,
    fetch_bus_error,
    illegal_instr,
    overflow,
    cache_addr_fault,
    dTlb_miss,
    cache_bus_error
  } xcpt_type_t;
  typedef struct packed {
    logic itlb_miss;
    logic bus_error;
    logic [XLEN-1:0] xcpt_pc;
    logic [XLEN-1:0] addr_val;
  } fetch_wb_t;
  typedef struct packed {
    logic illegal_instr;
    logic [XLEN-1:0] xcpt_pc;
  } decode_wb_t;
  typedef struct packed {
    logic overflow;
    logic [XLEN-1:0] xcpt_pc;
  } arith_wb_t;
  typedef struct packed {
    logic addr_fault;
    logic dtlb_miss;
    logic bus_error;
    logic [XLEN-1:0] xcpt_pc;
    logic [XLEN-1:0] addr_val;
  } cache_wb_t;
  typedef struct packed {
    fetch_wb_t fetch;
    decode_wb_t decode;
    arith_wb_t alu;
    arith_wb_t mul;
    cache_wb_t cache;
  } writeback_request_t;
  typedef struct packed {
    logic valid;
    xcpt_type_t xcpt_type;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr_val;
  } reorder_buffer_xcpt_info_t;
  function automatic reorder_buffer_xcpt_info_t mk_info(input xcpt_type_t t, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] addr_val);
    return '{valid: 1'b1, xcpt_type: t, pc: pc, addr_val: addr_val};
  endfunction
endpackage

// File: rtl/writeback_xcpt_arbiter_decode.sv
// writeback_xcpt_decode: fixed-priority translation of one writeback request (req) into one RoB exception record (info)
module writeback_xcpt_decode
  import writeback_xcpt_arbiter_pkg::*;
(
  input  writeback_request_t        req,
  output reorder_buffer_xcpt_info_t info
);
  assign info = req.fetch.itlb_miss     ? mk_info(iTlb_miss, req.fetch.xcpt_pc, req.fetch.addr_val)
              : req.fetch.bus_error     ? mk_info(fetch_bus_error, req.fetch.xcpt_pc, req.fetch.addr_val)
              : req.decode.illegal_instr ? mk_info(illegal_instr, req.decode.xcpt_pc, '0)
              : req.alu.overflow        ? mk_info(overflow, req.alu.xcpt_pc, '0)
              : req.mul.overflow        ? mk_info(overflow, req.mul.xcpt_pc, '0)
              : req.cache.addr_fault    ? mk_info(cache_addr_fault, req.cache.xcpt_pc, req.cache.addr_val)
              : req.cache.dtlb_miss     ? mk_info(dTlb_miss, req.cache.xcpt_pc, req.cache.addr_val)
              : req.cache.bus_error     ? mk_info(cache_bus_error, req.cache.xcpt_pc, req.cache.addr_val)
              : '0;
endmodule

// File: rtl/writeback_xcpt_arbiter.sv
// writeback_xcpt_arbiter: per-channel oldest-exception slots feeding one valid/ready output to the RoB (in: clock, reset, wb_*, rob_head_idx, flush, xcpt_ready; out: xcpt_valid/info/rob_idx, xcpt_pending, xcpt_drop_cnt)
module writeback_xcpt_arbiter
  import writeback_xcpt_arbiter_pkg::*;
#(
  parameter int NUM_WB_CH = 3,
  parameter int ROB_IDX_W = 3,
  parameter int DROP_CNT_W = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_WB_CH-1:0]                  wb_valid,
  input  writeback_request_t [NUM_WB_CH-1:0]    wb_req_info,
  input  logic [NUM_WB_CH-1:0][ROB_IDX_W-1:0]   wb_rob_idx,
  input  logic [ROB_IDX_W-1:0]                  rob_head_idx,
  input  logic                                  flush,
  output logic                                  xcpt_valid,
  output reorder_buffer_xcpt_info_t             xcpt_info,
  output logic [ROB_IDX_W-1:0]                  xcpt_rob_idx,
  input  logic                                  xcpt_ready,
  output logic [NUM_WB_CH-1:0]                  xcpt_pending,
  output logic [DROP_CNT_W-1:0]                 xcpt_drop_cnt
);
  localparam int CH_W = $clog2(NUM_WB_CH);
  reorder_buffer_xcpt_info_t [NUM_WB_CH-1:0] dec, slot_info;
  logic [NUM_WB_CH-1:0][ROB_IDX_W-1:0] slot_idx;
  logic [NUM_WB_CH-1:0] slot_valid, inc, take, drop, cap;
  logic [CH_W-1:0] sel;
  logic sel_any, load;
  logic [DROP_CNT_W+3:0] drop_sum;
  function automatic logic [ROB_IDX_W-1:0] age(input logic [ROB_IDX_W-1:0] idx);
    return idx - rob_head_idx;
  endfunction
  for (genvar c = 0; c < NUM_WB_CH; c++) begin : g_dec
    writeback_xcpt_decode u_dec (.req(wb_req_info[c]), .info(dec[c]));
  end
  assign xcpt_valid = xcpt_info.valid;
  assign xcpt_pending = slot_valid;
  assign load = !xcpt_valid || xcpt_ready;
  always_comb begin
    sel = '0;
    sel_any = 1'b0;
    for (int i = 0; i < NUM_WB_CH; i++)
      if (slot_valid[i] && (!sel_any || age(slot_idx[i]) < age(slot_idx[sel]))) begin
        sel = CH_W'(i);
        sel_any = 1'b1;
      end
  end
  always_comb begin
    for (int i = 0; i < NUM_WB_CH; i++) begin
      take[i] = load && sel_any && sel == CH_W'(i);
      inc[i] = wb_valid[i] && dec[i].valid;
      drop[i] = inc[i] && slot_valid[i] && !take[i];
      cap[i] = inc[i] && (!(slot_valid[i] && !take[i]) || age(wb_rob_idx[i]) < age(slot_idx[i]));
    end
    drop_sum = {4'b0, xcpt_drop_cnt} + (DROP_CNT_W+4)'($countones(drop));
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      slot_valid <= '0;
      slot_info <= '0;
      slot_idx <= '0;
      xcpt_info <= '0;
      xcpt_rob_idx <= '0;
      xcpt_drop_cnt <= '0;
    end else if (flush) begin
      slot_valid <= '0;
      xcpt_info <= '0;
      xcpt_rob_idx <= '0;
    end else begin
      xcpt_drop_cnt <= |drop_sum[DROP_CNT_W+3:DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      if (load) begin
        xcpt_info <= sel_any ? slot_info[sel] : '0;
        xcpt_rob_idx <= sel_any ? slot_idx[sel] : '0;
      end
      for (int i = 0; i < NUM_WB_CH; i++) begin
        if (take[i]) slot_valid[i] <= 1'b0;
        if (cap[i]) begin
          slot_valid[i] <= 1'b1;
          slot_info[i] <= dec[i];
          slot_idx[i] <= wb_rob_idx[i];
        end
      end
    end
endmodule

// File: tb/tb_writeback_xcpt_arbiter.sv
// tb_writeback_xcpt_arbiter: directed plus randomized checks of writeback_xcpt_arbiter against a priority-table / age-arithmetic reference model
module tb_writeback_xcpt_arbiter;
  import writeback_xcpt_arbiter_pkg::*;
  localparam int N = 3;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic xcpt_ready = 1'b0;
  logic [N-1:0] wb_valid = '0;
  writeback_request_t [N-1:0] wb_req_info = '0;
  logic [N-1:0][2:0] wb_rob_idx = '0;
  rob_idx_t rob_head_idx = '0;
  logic xcpt_valid;
  reorder_buffer_xcpt_info_t xcpt_info;
  logic [2:0] xcpt_rob_idx;
  logic [N-1:0] xcpt_pending;
  logic [7:0] xcpt_drop_cnt;
  int checks = 0;
  int failures = 0;
  bit m_sv [N];
  reorder_buffer_xcpt_info_t m_si [N];
  int m_sidx [N];
  reorder_buffer_xcpt_info_t m_out;
  int m_oidx;
  int m_drop;
  writeback_xcpt_arbiter #(.NUM_WB_CH(N), .ROB_IDX_W(3), .DROP_CNT_W(8)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_req_info(wb_req_info),
    .wb_rob_idx(wb_rob_idx), .rob_head_idx(rob_head_idx), .flush(flush),
    .xcpt_valid(xcpt_valid), .xcpt_info(xcpt_info), .xcpt_rob_idx(xcpt_rob_idx),
    .xcpt_ready(xcpt_ready), .xcpt_pending(xcpt_pending), .xcpt_drop_cnt(xcpt_drop_cnt)
  );
  always #5 clock = ~clock;
  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  function automatic int age(input int idx, input int head);
    return (idx - head + 8) % 8;
  endfunction
  function automatic reorder_buffer_xcpt_info_t ref_decode(input writeback_request_t r);
    logic hit [8];
    xcpt_type_t ty [8];
    logic [31:0] pc [8];
    logic [31:0] ad [8];
    hit = '{r.fetch.itlb_miss, r.fetch.bus_error, r.decode.illegal_instr, r.alu.overflow,
            r.mul.overflow, r.cache.addr_fault, r.cache.dtlb_miss, r.cache.bus_error};
    ty = '{iTlb_miss, fetch_bus_error, illegal_instr, overflow, overflow, cache_addr_fault, dTlb_miss, cache_bus_error};
    pc = '{r.fetch.xcpt_pc, r.fetch.xcpt_pc, r.decode.xcpt_pc, r.alu.xcpt_pc,
           r.mul.xcpt_pc, r.cache.xcpt_pc, r.cache.xcpt_pc, r.cache.xcpt_pc};
    ad = '{r.fetch.addr_val, r.fetch.addr_val, 32'h0, 32'h0, 32'h0, r.cache.addr_val, r.cache.addr_val, r.cache.addr_val};
    for (int k = 0; k < 8; k++)
      if (hit[k]) return '{valid: 1'b1, xcpt_type: ty[k], pc: pc[k], addr_val: ad[k]};
    return '0;
  endfunction
  function automatic writeback_request_t rnd_req();
    writeback_request_t r;
    for (int b = 0; b < $bits(r); b++) r[b] = 1'($urandom_range(0, 1));
    r.fetch.itlb_miss = $urandom_range(0, 7) == 0;
    r.fetch.bus_error = $urandom_range(0, 7) == 0;
    r.decode.illegal_instr = $urandom_range(0, 7) == 0;
    r.alu.overflow = $urandom_range(0, 7) == 0;
    r.mul.overflow = $urandom_range(0, 7) == 0;
    r.cache.addr_fault = $urandom_range(0, 7) == 0;
    r.cache.dtlb_miss = $urandom_range(0, 7) == 0;
    r.cache.bus_error = $urandom_range(0, 7) == 0;
    return r;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) m_sv[i] = 1'b0;
    m_out = '0;
    m_oidx = 0;
    m_drop = 0;
  endtask
  task automatic model_edge();
    int sel;
    int head;
    reorder_buffer_xcpt_info_t d;
    head = int'(rob_head_idx);
    if (flush) begin
      for (int i = 0; i < N; i++) m_sv[i] = 1'b0;
      m_out = '0;
      m_oidx = 0;
      return;
    end
    if (!m_out.valid || xcpt_ready) begin
      sel = -1;
      for (int i = 0; i < N; i++)
        if (m_sv[i] && (sel < 0 || age(m_sidx[i], head) < age(m_sidx[sel], head))) sel = i;
      m_out = '0;
      m_oidx = 0;
      if (sel >= 0) begin
        m_out = m_si[sel];
        m_oidx = m_sidx[sel];
        m_sv[sel] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      d = ref_decode(wb_req_info[i]);
      if (wb_valid[i] && d.valid) begin
        if (m_sv[i]) m_drop = m_drop < 255 ? m_drop + 1 : 255;
        if (!m_sv[i] || age(int'(wb_rob_idx[i]), head) < age(m_sidx[i], head)) begin
          m_sv[i] = 1'b1;
          m_si[i] = d;
          m_sidx[i] = int'(wb_rob_idx[i]);
        end
      end
    end
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cmp_model(input string tag);
    logic [N-1:0] pend;
    for (int i = 0; i < N; i++) pend[i] = m_sv[i];
    chk({tag, ".valid"}, 128'(xcpt_valid), 128'(m_out.valid));
    chk({tag, ".info"}, 128'(xcpt_info), 128'(m_out));
    chk({tag, ".idx"}, 128'(xcpt_rob_idx), 128'(m_oidx));
    chk({tag, ".pending"}, 128'(xcpt_pending), 128'(pend));
    chk({tag, ".drop"}, 128'(xcpt_drop_cnt), 128'(m_drop));
  endtask
  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    cmp_model(tag);
  endtask
  task automatic clr();
    wb_valid = '0;
    wb_req_info = '0;
    wb_rob_idx = '0;
  endtask
  initial begin
    model_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    cmp_model("reset");
    chk("reset.valid0", 128'(xcpt_valid), 128'(0));
    chk("reset.drop0", 128'(xcpt_drop_cnt), 128'(0));
    xcpt_ready = 1'b1;
    wb_valid[0] = 1'b1;
    wb_req_info[0].alu.overflow = 1'b1;
    wb_req_info[0].alu.xcpt_pc = 32'h100;
    wb_req_info[0].cache.dtlb_miss = 1'b1;
    wb_req_info[0].cache.xcpt_pc = 32'h200;
    wb_req_info[0].cache.addr_val = 32'hdead;
    wb_rob_idx[0] = 3'd2;
    step("prio_t1");
    chk("prio.t1_valid", 128'(xcpt_valid), 128'(0));
    chk("prio.t1_pending", 128'(xcpt_pending), 128'(3'b001));
    clr();
    step("prio_t2");
    chk("prio.t2_valid", 128'(xcpt_valid), 128'(1));
    chk("prio.type", 128'(xcpt_info.xcpt_type), 128'(overflow));
    chk("prio.pc", 128'(xcpt_info.pc), 128'(32'h100));
    chk("prio.addr", 128'(xcpt_info.addr_val), 128'(0));
    step("prio_t3");
    rob_head_idx = 3'd6;
    wb_valid = 3'b110;
    wb_req_info[1].decode.illegal_instr = 1'b1;
    wb_req_info[1].decode.xcpt_pc = 32'h70;
    wb_rob_idx[1] = 3'd7;
    wb_req_info[2].mul.overflow = 1'b1;
    wb_req_info[2].mul.xcpt_pc = 32'h10;
    wb_rob_idx[2] = 3'd1;
    step("wrap_t1");
    clr();
    step("wrap_t2");
    chk("wrap.first_idx", 128'(xcpt_rob_idx), 128'(7));
    step("wrap_t3");
    chk("wrap.second_idx", 128'(xcpt_rob_idx), 128'(1));
    step("wrap_t4");
    chk("wrap.drained", 128'(xcpt_valid), 128'(0));
    rob_head_idx = 3'd0;
    xcpt_ready = 1'b0;
    wb_valid[0] = 1'b1;
    wb_req_info[0].fetch.bus_error = 1'b1;
    wb_req_info[0].fetch.xcpt_pc = 32'h300;
    wb_req_info[0].fetch.addr_val = 32'h304;
    wb_rob_idx[0] = 3'd3;
    step("bp_t1");
    clr();
    step("bp_t2");
    chk("bp.first_idx", 128'(xcpt_rob_idx), 128'(3));
    wb_valid[2] = 1'b1;
    wb_req_info[2].cache.addr_fault = 1'b1;
    wb_req_info[2].cache.xcpt_pc = 32'h400;
    wb_rob_idx[2] = 3'd1;
    step("bp_hold");
    clr();
    for (int k = 0; k < 4; k++) step("bp_hold");
    chk("bp.held_idx", 128'(xcpt_rob_idx), 128'(3));
    chk("bp.held_type", 128'(xcpt_info.xcpt_type), 128'(fetch_bus_error));
    chk("bp.held_pending", 128'(xcpt_pending), 128'(3'b100));
    xcpt_ready = 1'b1;
    step("bp_release");
    chk("bp.next_idx", 128'(xcpt_rob_idx), 128'(1));
    chk("bp.next_type", 128'(xcpt_info.xcpt_type), 128'(cache_addr_fault));
    step("bp_drain");
    xcpt_ready = 1'b0;
    wb_valid[0] = 1'b1;
    wb_req_info[0].alu.overflow = 1'b1;
    wb_rob_idx[0] = 3'd6;
    step("slot_t1");
    clr();
    step("slot_t2");
    wb_valid[1] = 1'b1;
    wb_req_info[1].decode.illegal_instr = 1'b1;
    wb_req_info[1].decode.xcpt_pc = 32'h44;
    wb_rob_idx[1] = 3'd4;
    step("slot_fill");
    chk("slot.pending", 128'(xcpt_pending), 128'(3'b010));
    wb_req_info[1].decode.xcpt_pc = 32'h22;
    wb_rob_idx[1] = 3'd2;
    step("slot_replace");
    chk("slot.drop1", 128'(xcpt_drop_cnt), 128'(1));
    wb_req_info[1].decode.xcpt_pc = 32'h55;
    wb_rob_idx[1] = 3'd5;
    step("slot_discard");
    chk("slot.drop2", 128'(xcpt_drop_cnt), 128'(2));
    clr();
    xcpt_ready = 1'b1;
    step("slot_out");
    chk("slot.kept_idx", 128'(xcpt_rob_idx), 128'(2));
    chk("slot.kept_pc", 128'(xcpt_info.pc), 128'(32'h22));
    step("slot_drain");
    xcpt_ready = 1'b0;
    wb_valid[0] = 1'b1;
    wb_req_info[0].mul.overflow = 1'b1;
    wb_rob_idx[0] = 3'd1;
    step("fl_t1");
    clr();
    step("fl_t2");
    wb_valid = 3'b111;
    wb_req_info[0].mul.overflow = 1'b1;
    wb_req_info[1].alu.overflow = 1'b1;
    wb_req_info[2].cache.dtlb_miss = 1'b1;
    wb_rob_idx = {3'd4, 3'd3, 3'd2};
    step("fl_fill");
    chk("fl.full", 128'(xcpt_pending), 128'(3'b111));
    clr();
    flush = 1'b1;
    wb_valid[0] = 1'b1;
    wb_req_info[0].alu.overflow = 1'b1;
    wb_rob_idx[0] = 3'd5;
    step("fl_edge");
    chk("fl.valid", 128'(xcpt_valid), 128'(0));
    chk("fl.pending", 128'(xcpt_pending), 128'(0));
    chk("fl.drop", 128'(xcpt_drop_cnt), 128'(2));
    flush = 1'b0;
    clr();
    step("fl_after");
    chk("fl.no_capture", 128'(xcpt_pending), 128'(0));
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        wb_valid[i] = 1'($urandom_range(0, 1));
        wb_req_info[i] = rnd_req();
        wb_rob_idx[i] = 3'($urandom);
      end
      if ($urandom_range(0, 7) == 0) rob_head_idx = 3'($urandom);
      xcpt_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 40) == 0;
      step("rand");
    end
    flush = 1'b0;
    clr();
    xcpt_ready = 1'b0;
    rob_head_idx = 3'd0;
    wb_valid[0] = 1'b1;
    wb_req_info[0].alu.overflow = 1'b1;
    wb_rob_idx[0] = 3'd0;
    for (int k = 0; k < 302; k++) step("sat");
    chk("sat.drop", 128'(xcpt_drop_cnt), 128'(255));
    chk("sat.valid", 128'(xcpt_valid), 128'(1));
    clr();
    #3;
    reset = 1'b1;
    #1;
    chk("areset.valid", 128'(xcpt_valid), 128'(0));
    chk("areset.info", 128'(xcpt_info), 128'(0));
    chk("areset.idx", 128'(xcpt_rob_idx), 128'(0));
    chk("areset.pending", 128'(xcpt_pending), 128'(0));
    chk("areset.drop", 128'(xcpt_drop_cnt), 128'(0));
    model_reset();
    #2;
    reset = 1'b0;
    step("post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
